// File: rtl/adpll_pkg.sv
// Shared types, constants and arithmetic helpers for the ADPLL loop filter.
// The integrator and the proportional path both saturate through sat_add.
package adpll_pkg;

  localparam int DEF_ERR_W = 8;
  localparam int DEF_SEL_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_TRACK  = 2'd2,
    ST_LOCKED = 2'd3
  } state_e;

  // Centre frequency code for a given select width.
  function automatic int mid_code(input int sel_w);
    mid_code = 32'sd1 <<< (sel_w - 32'sd1);
  endfunction

  localparam int MID_CODE = mid_code(DEF_SEL_W);

  // Signed add, clamped into [0, hi]. Operands are far narrower than 32 bits.
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input logic signed [31:0] hi);
    logic signed [31:0] s;
    s = a + b;
    if (s < 32'sd0) begin
      sat_add = 32'sd0;
    end else if (s > hi) begin
      sat_add = hi;
    end else begin
      sat_add = s;
    end
  endfunction

endpackage

// File: rtl/adpll_lock_detect.sv
// Lock qualifier: counts consecutive small errors to enter lock and uses a
// wider exit threshold so moderate errors do not drop lock (hysteresis).
module adpll_lock_detect
  import adpll_pkg::*;
#(
  parameter int ABS_W    = DEF_ERR_W + 1,
  parameter int LOCK_TOL = 2,
  parameter int LOCK_CNT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             valid,
  input  logic [ABS_W-1:0] abs_err,
  output logic             locked_next,
  output logic             locked
);

  localparam int CNT_W = $clog2(LOCK_CNT + 1);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             locked_r;
  logic             locked_nxt_s;
  logic             in_tol_s;
  logic             far_s;

  assign in_tol_s = (abs_err <= ABS_W'(LOCK_TOL));
  assign far_s    = (abs_err > ABS_W'(4 * LOCK_TOL));

  // Next lock counter and lock flag for the current sample.
  always_comb begin
    cnt_nxt_s    = cnt_r;
    locked_nxt_s = locked_r;
    if (clr) begin
      cnt_nxt_s    = {CNT_W{1'b0}};
      locked_nxt_s = 1'b0;
    end else if (valid) begin
      if (locked_r) begin
        cnt_nxt_s = {CNT_W{1'b0}};
        if (far_s) begin
          locked_nxt_s = 1'b0;
        end else begin
          locked_nxt_s = 1'b1;
        end
      end else if (in_tol_s) begin
        if (cnt_r == CNT_W'(LOCK_CNT - 1)) begin
          cnt_nxt_s    = {CNT_W{1'b0}};
          locked_nxt_s = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end else begin
        cnt_nxt_s = {CNT_W{1'b0}};
      end
    end else begin
      cnt_nxt_s    = cnt_r;
      locked_nxt_s = locked_r;
    end
  end

  // Lock state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r    <= {CNT_W{1'b0}};
      locked_r <= 1'b0;
    end else begin
      cnt_r    <= cnt_nxt_s;
      locked_r <= locked_nxt_s;
    end
  end

  assign locked_next = locked_nxt_s;
  assign locked      = locked_r;

endmodule

// File: rtl/adpll_loop_filter.sv
// Proportional-integral loop filter driving the ring oscillator frequency code,
// with start-up settling and lock reporting.
module adpll_loop_filter
  import adpll_pkg::*;
#(
  parameter int ERR_W      = DEF_ERR_W,
  parameter int SEL_W      = DEF_SEL_W,
  parameter int FRAC_W     = 8,
  parameter int KP_SHIFT   = 2,
  parameter int KI_SHIFT   = 5,
  parameter int SETTLE_CYC = 32,
  parameter int LOCK_TOL   = 2,
  parameter int LOCK_CNT   = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             enable_i,
  input  logic [ERR_W-1:0] err_i,
  input  logic             err_valid_i,
  output logic [SEL_W-1:0] sel_o,
  output logic             sel_valid_o,
  output logic             osc_enable_o,
  output logic             locked_o
);

  localparam int W      = SEL_W + FRAC_W;
  localparam int SCNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic signed [31:0] INTEG_MAX = (32'sd1 <<< W) - 32'sd1;
  localparam logic [SEL_W-1:0]   MID_SEL   = SEL_W'(mid_code(SEL_W));
  localparam logic [W-1:0]       MID_INTEG = {MID_SEL, {FRAC_W{1'b0}}};

  state_e              state_r;
  state_e              state_nxt_s;
  logic [SCNT_W-1:0]   settle_cnt_r;
  logic [SCNT_W-1:0]   settle_cnt_nxt_s;
  logic [W-1:0]        integ_r;
  logic [SEL_W-1:0]    sel_r;
  logic                sel_valid_r;
  logic                osc_en_r;
  logic                tracking_s;
  logic                sample_s;
  logic                lock_next_s;
  logic                locked_s;
  logic signed [31:0]  err_ext_s;
  logic signed [31:0]  integ_n_s;
  logic signed [31:0]  sum_s;
  logic signed [ERR_W:0] err_wide_s;
  logic [ERR_W:0]      abs_err_s;
  logic                unused_s;

  assign tracking_s = enable_i && ((state_r == ST_TRACK) || (state_r == ST_LOCKED));
  assign sample_s   = tracking_s && err_valid_i;
  assign err_ext_s  = {{(32 - ERR_W){err_i[ERR_W-1]}}, err_i};
  assign err_wide_s = {err_i[ERR_W-1], err_i};

  // PI update; the nine-bit magnitude keeps the most negative error unwrapped.
  always_comb begin
    integ_n_s = sat_add($signed({{(32 - W){1'b0}}, integ_r}),
                        err_ext_s <<< (FRAC_W - KI_SHIFT), INTEG_MAX);
    sum_s     = sat_add(integ_n_s, err_ext_s <<< (FRAC_W - KP_SHIFT), INTEG_MAX);
    if (err_i[ERR_W-1]) begin
      abs_err_s = (ERR_W + 1)'(-err_wide_s);
    end else begin
      abs_err_s = err_wide_s;
    end
  end

  assign unused_s = ^{integ_n_s[31:W], sum_s[31:W], sum_s[FRAC_W-1:0]};

  // Next-state logic; enable low overrides every state.
  always_comb begin
    state_nxt_s      = state_r;
    settle_cnt_nxt_s = settle_cnt_r;
    if (!enable_i) begin
      state_nxt_s      = ST_IDLE;
      settle_cnt_nxt_s = {SCNT_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_nxt_s      = ST_SETTLE;
          settle_cnt_nxt_s = {SCNT_W{1'b0}};
        end
        ST_SETTLE: begin
          if (settle_cnt_r == SCNT_W'(SETTLE_CYC - 1)) begin
            state_nxt_s      = ST_TRACK;
            settle_cnt_nxt_s = {SCNT_W{1'b0}};
          end else begin
            settle_cnt_nxt_s = settle_cnt_r + SCNT_W'(1);
          end
        end
        ST_TRACK, ST_LOCKED: begin
          if (lock_next_s) begin
            state_nxt_s = ST_LOCKED;
          end else begin
            state_nxt_s = ST_TRACK;
          end
        end
        default: begin
          state_nxt_s      = ST_IDLE;
          settle_cnt_nxt_s = {SCNT_W{1'b0}};
        end
      endcase
    end
  end

  // State, integrator and output registers.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_r      <= ST_IDLE;
      settle_cnt_r <= {SCNT_W{1'b0}};
      integ_r      <= MID_INTEG;
      sel_r        <= MID_SEL;
      sel_valid_r  <= 1'b0;
      osc_en_r     <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      settle_cnt_r <= settle_cnt_nxt_s;
      sel_valid_r  <= sample_s;
      osc_en_r     <= (state_nxt_s != ST_IDLE);
      if (sample_s) begin
        integ_r <= integ_n_s[W-1:0];
        sel_r   <= sum_s[W-1:FRAC_W];
      end else if (!tracking_s) begin
        integ_r <= MID_INTEG;
        sel_r   <= MID_SEL;
      end else begin
        integ_r <= integ_r;
        sel_r   <= sel_r;
      end
    end
  end

  adpll_lock_detect #(
    .ABS_W   (ERR_W + 1),
    .LOCK_TOL(LOCK_TOL),
    .LOCK_CNT(LOCK_CNT)
  ) u_lock (
    .clk        (clk_i),
    .rst_n      (rst_n_i),
    .clr        (!tracking_s),
    .valid      (sample_s),
    .abs_err    (abs_err_s),
    .locked_next(lock_next_s),
    .locked     (locked_s)
  );

  assign sel_o        = sel_r;
  assign sel_valid_o  = sel_valid_r;
  assign osc_enable_o = osc_en_r;
  assign locked_o     = locked_s;

endmodule
